// File: rtl/aes_input_queue.sv
// rtl/aes_input_queue.sv - text/key staging FIFO feeding the AES round-pipe new-block inputs
// Optional AES_QUEUE_STATS_EN adds stall_cnt/pop_cnt counters.
module aes_input_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [127:0]      wr_text,
   input  logic [127:0]      wr_key,
   input  logic              loop_empty,
   input  logic [7:0]        loop_rcon,
   output logic [7:0]        qn0,
   output logic [7:0]        qn1,
   output logic [7:0]        qn2,
   output logic [7:0]        qn3,
   output logic [7:0]        qn4,
   output logic [7:0]        qn5,
   output logic [7:0]        qn6,
   output logic [7:0]        qn7,
   output logic [7:0]        qn8,
   output logic [7:0]        qn9,
   output logic [7:0]        qnA,
   output logic [7:0]        qnB,
   output logic [7:0]        qnC,
   output logic [7:0]        qnD,
   output logic [7:0]        qnE,
   output logic [7:0]        qnF,
   output logic [7:0]        qnk0,
   output logic [7:0]        qnk1,
   output logic [7:0]        qnk2,
   output logic [7:0]        qnk3,
   output logic [7:0]        qnk4,
   output logic [7:0]        qnk5,
   output logic [7:0]        qnk6,
   output logic [7:0]        qnk7,
   output logic [7:0]        qnk8,
   output logic [7:0]        qnk9,
   output logic [7:0]        qnkA,
   output logic [7:0]        qnkB,
   output logic [7:0]        qnkC,
   output logic [7:0]        qnkD,
   output logic [7:0]        qnkE,
   output logic [7:0]        qnkF,
   output logic              empty_qn,
   output logic [ADDR_W:0]   level,
`ifdef AES_QUEUE_STATS_EN
   output logic [15:0]       stall_cnt,
   output logic [15:0]       pop_cnt,
`endif
   output logic              full
);

   localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W+1)'(DEPTH);

   logic [127:0]      r_text [DEPTH];
   logic [127:0]      r_key  [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_level;
   logic              r_empty;
   logic [127:0]      r_head_text;
   logic [127:0]      r_head_key;

   logic              w_full;
   logic              w_take;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_rd_next;
   logic [ADDR_W:0]   w_level_next;
   logic [127:0]      w_head_text;
   logic [127:0]      w_head_key;

   // Same select condition the pipe register uses for its new-block path.
   assign w_take = loop_empty || (loop_rcon == 8'h36);
   assign w_full = (r_level == LEVEL_FULL);
   assign w_push = wr_valid && !w_full;
   assign w_pop  = w_take && !r_empty;

   always_comb begin
      w_rd_next    = r_rd_ptr;
      w_level_next = r_level;
      w_head_text  = 128'h0;
      w_head_key   = 128'h0;
      if (w_pop)
         w_rd_next = r_rd_ptr + 1'b1;
      if (w_push && !w_pop)
         w_level_next = r_level + 1'b1;
      else if (w_pop && !w_push)
         w_level_next = r_level - 1'b1;
      // The slot being written this edge can already be the next head; bypass it.
      if (w_level_next != '0) begin
         if (w_push && (r_wr_ptr == w_rd_next)) begin
            w_head_text = wr_text;
            w_head_key  = wr_key;
         end else begin
            w_head_text = r_text[w_rd_next];
            w_head_key  = r_key[w_rd_next];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_text[r_wr_ptr] <= wr_text;
         r_key[r_wr_ptr]  <= wr_key;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_empty     <= 1'b1;
         r_head_text <= 128'h0;
         r_head_key  <= 128'h0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         r_rd_ptr    <= w_rd_next;
         r_level     <= w_level_next;
         r_empty     <= (w_level_next == '0);
         r_head_text <= w_head_text;
         r_head_key  <= w_head_key;
      end
   end

`ifdef AES_QUEUE_STATS_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_pop_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_stall_cnt <= 16'h0;
         r_pop_cnt   <= 16'h0;
      end else begin
         if (wr_valid && w_full && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'h1;
         if (w_pop)
            r_pop_cnt <= r_pop_cnt + 16'h1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign pop_cnt   = r_pop_cnt;
`endif

   assign wr_ready = !w_full;
   assign full     = w_full;
   assign level    = r_level;
   assign empty_qn = r_empty;

   assign {qn0, qn1, qn2, qn3, qn4, qn5, qn6, qn7,
           qn8, qn9, qnA, qnB, qnC, qnD, qnE, qnF} = r_head_text;
   assign {qnk0, qnk1, qnk2, qnk3, qnk4, qnk5, qnk6, qnk7,
           qnk8, qnk9, qnkA, qnkB, qnkC, qnkD, qnkE, qnkF} = r_head_key;

endmodule

// File: tb/tb_aes_input_queue.sv
// tb/tb_aes_input_queue.sv - directed self-checking bench for aes_input_queue
module tb_aes_input_queue;

   logic         clock = 1'b0;
   logic         reset;
   logic         wr_valid;
   logic         wr_ready;
   logic [127:0] wr_text;
   logic [127:0] wr_key;
   logic         loop_empty;
   logic [7:0]   loop_rcon;
   logic [7:0]   qn0, qn1, qn2, qn3, qn4, qn5, qn6, qn7;
   logic [7:0]   qn8, qn9, qnA, qnB, qnC, qnD, qnE, qnF;
   logic [7:0]   qnk0, qnk1, qnk2, qnk3, qnk4, qnk5, qnk6, qnk7;
   logic [7:0]   qnk8, qnk9, qnkA, qnkB, qnkC, qnkD, qnkE, qnkF;
   logic         empty_qn;
   logic [2:0]   level;
   logic         full;
`ifdef AES_QUEUE_STATS_EN
   logic [15:0]  stall_cnt;
   logic [15:0]  pop_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   aes_input_queue #(.DEPTH(4), .ADDR_W(2)) dut (
      .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_text(wr_text), .wr_key(wr_key), .loop_empty(loop_empty), .loop_rcon(loop_rcon),
      .qn0(qn0), .qn1(qn1), .qn2(qn2), .qn3(qn3), .qn4(qn4), .qn5(qn5), .qn6(qn6), .qn7(qn7),
      .qn8(qn8), .qn9(qn9), .qnA(qnA), .qnB(qnB), .qnC(qnC), .qnD(qnD), .qnE(qnE), .qnF(qnF),
      .qnk0(qnk0), .qnk1(qnk1), .qnk2(qnk2), .qnk3(qnk3), .qnk4(qnk4), .qnk5(qnk5),
      .qnk6(qnk6), .qnk7(qnk7), .qnk8(qnk8), .qnk9(qnk9), .qnkA(qnkA), .qnkB(qnkB),
      .qnkC(qnkC), .qnkD(qnkD), .qnkE(qnkE), .qnkF(qnkF),
      .empty_qn(empty_qn), .level(level),
`ifdef AES_QUEUE_STATS_EN
      .stall_cnt(stall_cnt), .pop_cnt(pop_cnt),
`endif
      .full(full)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_entry(input logic [127:0] t, input logic [127:0] k);
      wr_valid = 1'b1;
      wr_text  = t;
      wr_key   = k;
      step();
      wr_valid = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      wr_valid   = 1'b0;
      wr_text    = '0;
      wr_key     = '0;
      loop_empty = 1'b0;
      loop_rcon  = 8'h02;
      step();
      step();
      reset = 1'b0;
      step();

      check("rst_empty", empty_qn, 1);
      check("rst_level", level, 0);
      check("rst_ready", wr_ready, 1);
      check("rst_full", full, 0);
      check("rst_qn0", qn0, 0);
      check("rst_qnk0", qnk0, 0);

      push_entry(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
      check("push_qn0", qn0, 8'h00);
      check("push_qn1", qn1, 8'h11);
      check("push_qnF", qnF, 8'hff);
      check("push_qnkF", qnkF, 8'h0f);
      check("push_empty", empty_qn, 0);
      check("push_level", level, 1);
      step();
      step();
      check("hold_level", level, 1);
      check("hold_qn1", qn1, 8'h11);

      loop_rcon = 8'h36;
      step();
      loop_rcon = 8'h02;
      check("pop36_level", level, 0);
      check("pop36_empty", empty_qn, 1);
      check("pop36_qn1", qn1, 8'h00);
      check("pop36_qnkF", qnkF, 8'h00);

      push_entry(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
      check("push2_level", level, 1);
      loop_empty = 1'b1;
      loop_rcon  = 8'h04;
      step();
      loop_empty = 1'b0;
      loop_rcon  = 8'h02;
      check("popempty_level", level, 0);
      check("popempty_empty", empty_qn, 1);

      for (int i = 0; i < 5; i++) begin
         push_entry({8'h10 + 8'(i), 120'h0}, {8'h20 + 8'(i), 120'h0});
         if (i == 3) begin
            check("fill_full", full, 1);
            check("fill_ready", wr_ready, 0);
         end
      end
      check("fill_level", level, 4);
      check("fill_head", qn0, 8'h10);

      loop_rcon = 8'h36;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("drain_qn0_%0d", i), qn0, (i < 4) ? 8'h10 + 8'(i) : 8'h00);
         check($sformatf("drain_qnk0_%0d", i), qnk0, (i < 4) ? 8'h20 + 8'(i) : 8'h00);
         check($sformatf("drain_empty_%0d", i), empty_qn, (i >= 4) ? 1 : 0);
         step();
      end
      loop_rcon = 8'h02;
      check("drain_level", level, 0);

      push_entry({8'hA0, 120'h0}, {8'hB0, 120'h0});
      push_entry({8'hA1, 120'h0}, {8'hB1, 120'h0});
      check("sim_pre_level", level, 2);
      check("sim_pre_head", qn0, 8'hA0);
      loop_rcon = 8'h36;
      for (int k = 0; k < 4; k++) begin
         push_entry({8'hA2 + 8'(k), 120'h0}, {8'hB2 + 8'(k), 120'h0});
         check($sformatf("sim_level_%0d", k), level, 2);
         check($sformatf("sim_head_%0d", k), qn0, 8'hA1 + 8'(k));
         check($sformatf("sim_key_%0d", k), qnk0, 8'hB1 + 8'(k));
      end
      step();
      check("sim_tail_head", qn0, 8'hA5);
      check("sim_tail_level", level, 1);
      step();
      check("sim_tail_empty", empty_qn, 1);
      loop_rcon = 8'h02;

      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst2_level", level, 0);
`ifdef AES_QUEUE_STATS_EN
      check("rst2_stall", stall_cnt, 0);
      check("rst2_pop", pop_cnt, 0);
`endif
      for (int i = 0; i < 4; i++)
         push_entry({8'hC0 + 8'(i), 120'h0}, {8'hD0 + 8'(i), 120'h0});
      check("stall_full", full, 1);
      wr_valid = 1'b1;
      wr_text  = {8'hEE, 120'h0};
      step();
      step();
      step();
      check("stall_level", level, 4);
`ifdef AES_QUEUE_STATS_EN
      check("stall_cnt3", stall_cnt, 3);
`endif
      loop_rcon = 8'h36;
      step();
      wr_valid  = 1'b0;
      loop_rcon = 8'h02;
      check("fullpop_level", level, 3);
      check("fullpop_head", qn0, 8'hC1);
      step();
      check("fullpop_nowrite", level, 3);
`ifdef AES_QUEUE_STATS_EN
      check("pop_cnt1", pop_cnt, 1);
`endif
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst3_level", level, 0);
      check("rst3_empty", empty_qn, 1);
      check("rst3_full", full, 0);
      check("rst3_qn0", qn0, 0);
`ifdef AES_QUEUE_STATS_EN
      check("rst3_stall", stall_cnt, 0);
      check("rst3_pop", pop_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
